// File: rtl/bus_transfer_sequencer.sv
// Purpose: initiator of the shared register bus; turns (src,dst) transfer requests into one-hot en/set strobes.
// Latency: handshake in cycle 0 -> en_o cycles 1-3, set_o cycle 2, done in cycle 4 (3-cycle cadence when queued).
// Backpressure: req_ready only in IDLE; with BUS_XFER_FIFO_EN a 2-entry queue accepts while not full.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_src/req_dst are register indices
//   en_o, set_o           one-hot bus drive enables / load strobes (registered)
//   bus_i                 wired-OR bus value, captured into xfer_data at the end of the set cycle
//   done, err             one-cycle completion / rejection pulses
//   busy                  FSM is not IDLE
//
// Optional feature: define BUS_XFER_FIFO_EN to add a 2-entry request queue ahead
// of the FSM, letting a queued transfer start straight out of HOLD.
module bus_transfer_sequencer #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [$clog2(NREG)-1:0] req_src,
  input  logic [$clog2(NREG)-1:0] req_dst,
  output logic [NREG-1:0]         en_o,
  output logic [NREG-1:0]         set_o,
  input  logic [WIDTH-1:0]        bus_i,
  output logic [WIDTH-1:0]        xfer_data,
  output logic                    done,
  output logic                    err,
  output logic                    busy
);

  localparam int IDX_W = $clog2(NREG);
  localparam logic [NREG-1:0] ONE = NREG'(1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t           state;
  logic [IDX_W-1:0] dst_q;

  logic             hs;
  logic             req_ok;
  logic             bad_hs;
  logic             take;      // launch a transfer on this edge
  logic [IDX_W-1:0] nxt_src;
  logic [IDX_W-1:0] nxt_dst;
  logic [1:0]       err_pend;
  logic [1:0]       pend_sum;

  assign hs     = req_valid & req_ready;
  // Index range checks are done on 32-bit values so that a non-power-of-two
  // NREG rejects out-of-range indices that still fit in IDX_W bits.
  assign req_ok = (32'(req_src) < 32'(NREG)) && (32'(req_dst) < 32'(NREG)) &&
                  (req_src != req_dst);
  assign bad_hs = hs & ~req_ok;
  assign busy   = (state != IDLE);

`ifdef BUS_XFER_FIFO_EN
  logic [IDX_W-1:0] q_src [2];
  logic [IDX_W-1:0] q_dst [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       q_cnt;
  logic             push;

  // The FSM drains the queue both from IDLE and straight out of HOLD.
  assign take      = (q_cnt != 2'd0) && ((state == IDLE) || (state == HOLD));
  // A full queue still accepts when an entry leaves in the same cycle.
  assign req_ready = (q_cnt != 2'd2) || take;
  assign push      = hs & req_ok;
  assign nxt_src   = q_src[rd_ptr];
  assign nxt_dst   = q_dst[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      q_cnt  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (take) rd_ptr <= ~rd_ptr;
      q_cnt <= q_cnt + {1'b0, push} - {1'b0, take};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_src[wr_ptr] <= req_src;
      q_dst[wr_ptr] <= req_dst;
    end
  end
`else
  assign req_ready = (state == IDLE);
  assign take      = hs & req_ok;
  assign nxt_src   = req_src;
  assign nxt_dst   = req_dst;
`endif

  // Rejections are counted so that one landing on the cycle a done pulse is
  // due is issued a cycle later instead of colliding with done.
  always_comb begin
    pend_sum = err_pend + {1'b0, bad_hs};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dst_q     <= '0;
      en_o      <= '0;
      set_o     <= '0;
      xfer_data <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_pend  <= 2'd0;
    end else begin
      done <= 1'b0;

      if ((state == HOLD) || (pend_sum == 2'd0)) begin
        err      <= 1'b0;
        err_pend <= pend_sum;
      end else begin
        err      <= 1'b1;
        err_pend <= pend_sum - 2'd1;
      end

      case (state)
        IDLE: begin
          if (take) begin
            state <= SETUP;
            dst_q <= nxt_dst;
            en_o  <= ONE << nxt_src;
          end
        end
        SETUP: begin
          state <= STROBE;
          set_o <= ONE << dst_q;
        end
        STROBE: begin
          // set_o falls while en_o keeps the bus driven for the hold cycle.
          state     <= HOLD;
          set_o     <= '0;
          xfer_data <= bus_i;
        end
        HOLD: begin
          done <= 1'b1;
          if (take) begin
            state <= SETUP;
            dst_q <= nxt_dst;
            en_o  <= ONE << nxt_src;
          end else begin
            state <= IDLE;
            en_o  <= '0;
          end
        end
        default: begin
          state <= IDLE;
          en_o  <= '0;
          set_o <= '0;
        end
      endcase
    end
  end

endmodule
